// File: rtl/spi_param_interface_pkg.sv
`default_nettype none
// ============================================================================
// Module   : spi_if_pkg
// Purpose  : Shared opcode values and frame-FSM state encoding for the
//            parametrised SPI configuration slave.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package spi_if_pkg;

   localparam logic [7:0] OP_READ      = 8'h00;
   localparam logic [7:0] OP_WR        = 8'h01;
   localparam logic [7:0] OP_WR_CLKDIV = 8'h05;
   localparam logic [7:0] OP_WR_SPIKE  = 8'h07;
   localparam logic [7:0] OP_WR_DEBUG  = 8'h09;
   localparam logic [7:0] OP_BURST_WR  = 8'h0B;
   localparam logic [7:0] OP_BURST_RD  = 8'h0C;
   localparam logic [7:0] OP_CLR_ERR   = 8'h0F;

   typedef enum logic [2:0] {
      ST_ADDR_H = 3'd0,
      ST_ADDR_L = 3'd1,
      ST_OP     = 3'd2,
      ST_DATA   = 3'd3,
      ST_BURST  = 3'd4
   } state_t;

endpackage
`default_nettype wire

// File: rtl/spi_param_interface_if.sv
`default_nettype none
// ============================================================================
// Module   : spi_param_interface_if
// Purpose  : SPI serial bus bundle (frame select, data in, data out).
// Signals  : SS   - active-low byte frame select (master -> slave)
//            MOSI - serial data, MSB first     (master -> slave)
//            MISO - serial data, MSB first     (slave  -> master)
// Revision : 1.0 - initial release
// ============================================================================
interface spi_param_interface_if;
   logic SS;
   logic MOSI;
   logic MISO;

   modport slave  (input SS, input MOSI, output MISO);
   modport master (output SS, output MOSI, input MISO);
endinterface
`default_nettype wire

// File: rtl/spi_param_interface_byte_shifter.sv
`default_nettype none
// ============================================================================
// Module   : spi_byte_shifter
// Purpose  : Byte framing for the SPI slave: RX/TX shift registers and bit
//            counter. A byte completes on the 8th SS-low rising edge.
// Ports    : clk, rst     - SPI clock, async active-high reset
//            i_ss, i_mosi - frame select (active low), serial data in
//            i_tx_data    - byte loaded into TX on byte completion
//            o_rx_byte    - completed byte (valid while o_byte_done)
//            o_byte_done  - high during the cycle whose edge completes a byte
//            o_miso       - TX shifter MSB
// Revision : 1.0 - initial release
// ============================================================================
module spi_byte_shifter (
   input  logic       clk,
   input  logic       rst,
   input  logic       i_ss,
   input  logic       i_mosi,
   input  logic [7:0] i_tx_data,
   output logic [7:0] o_rx_byte,
   output logic       o_byte_done,
   output logic       o_miso
);
   logic [2:0] r_bit_cnt;
   logic [6:0] r_rx;
   logic [7:0] r_tx;

   // The completing edge samples the 8th bit directly from MOSI so the
   // whole byte is usable by the FSM on that same edge.
   assign o_byte_done = ~i_ss & (r_bit_cnt == 3'd7);
   assign o_rx_byte   = {r_rx, i_mosi};
   assign o_miso      = r_tx[7];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_bit_cnt <= 3'd0;
         r_rx      <= 7'd0;
         r_tx      <= 8'd0;
      end else begin
         // SS high discards any partial byte
         if (i_ss) begin
            r_bit_cnt <= 3'd0;
         end else begin
            r_bit_cnt <= r_bit_cnt + 3'd1;
            r_rx      <= {r_rx[5:0], i_mosi};
         end
         // Reload every byte; a zero load keeps MISO low when not reading
         if (o_byte_done) begin
            r_tx <= i_tx_data;
         end else if (!i_ss) begin
            r_tx <= {r_tx[6:0], 1'b0};
         end
      end
   end
endmodule
`default_nettype wire

// File: rtl/spi_param_interface.sv
`default_nettype none
// ============================================================================
// Module   : spi_param_interface
// Purpose  : SPI configuration slave writing a parametrised byte memory with
//            read-back, burst access and sticky error flags.
// Ports    : SCLK, RESET                - clock, async active-high reset
//            spi (slave modport)        - SS / MOSI / MISO
//            all_data_out               - memory image, byte k at [8k+7:8k]
//            clk_div/input_spike/debug_config_ready_reg_out - 1-cycle pulses
//            data_valid_out             - 1-cycle pulse per committed write
//            spi_instruction_done       - 1-cycle pulse after final byte
//            err_sticky                 - [0] addr out of range, [1] bad op
// Revision : 1.0 - initial release
// ============================================================================
module spi_param_interface
   import spi_if_pkg::*;
#(
   parameter int MEM_BYTES   = 164,
   parameter int ADDR_W      = 16,
   parameter int SPIKE_BYTES = 3,
   parameter int CLKDIV_ADDR = 6,
   parameter int DEBUG_ADDR  = 163
) (
   input  logic                   SCLK,
   input  logic                   RESET,
   spi_param_interface_if.slave   spi,
   output logic [MEM_BYTES*8-1:0] all_data_out,
   output logic                   clk_div_ready_reg_out,
   output logic                   input_spike_ready_reg_out,
   output logic                   debug_config_ready_reg_out,
   output logic                   data_valid_out,
   output logic                   spi_instruction_done,
   output logic [1:0]             err_sticky
);
   localparam int                IDX_W        = $clog2(MEM_BYTES);
   localparam logic [ADDR_W:0]   c_mem_limit  = (ADDR_W+1)'(MEM_BYTES);
   localparam logic [ADDR_W-1:0] c_clkdiv     = ADDR_W'(CLKDIV_ADDR);
   localparam logic [ADDR_W-1:0] c_spike_last = ADDR_W'(SPIKE_BYTES - 1);
   localparam logic [ADDR_W-1:0] c_debug      = ADDR_W'(DEBUG_ADDR);

   logic [7:0]        w_rx_byte, w_tx_data, w_rd_byte;
   logic              w_byte_done, w_miso;
   state_t            r_state, w_state_nxt;
   logic [7:0]        r_addr_h, w_addr_h_nxt, r_op, w_op_nxt, r_cnt, w_cnt_nxt;
   logic [ADDR_W-1:0] r_addr, w_addr_nxt, w_rd_addr;
   logic              w_wr_ok, w_rd_ok, w_wr_en, w_err_clr;
   logic              w_dv, w_ck, w_sp, w_dbg, w_done;
   logic [1:0]        w_err_set, r_err;
   logic              r_dv, r_ck, r_sp, r_dbg, r_done;
   logic [7:0]        r_mem [MEM_BYTES];

   spi_byte_shifter u_shifter (
      .clk         (SCLK),
      .rst         (RESET),
      .i_ss        (spi.SS),
      .i_mosi      (spi.MOSI),
      .i_tx_data   (w_tx_data),
      .o_rx_byte   (w_rx_byte),
      .o_byte_done (w_byte_done),
      .o_miso      (w_miso)
   );
   assign spi.MISO = w_miso;

   // During a burst the TX load prepares the byte after the current one
   assign w_rd_addr = (r_state == ST_BURST) ? r_addr + ADDR_W'(1) : r_addr;
   assign w_rd_ok   = {1'b0, w_rd_addr} < c_mem_limit;
   assign w_wr_ok   = {1'b0, r_addr} < c_mem_limit;
   assign w_rd_byte = w_rd_ok ? r_mem[w_rd_addr[IDX_W-1:0]] : 8'h00;

   always_ff @(posedge SCLK or posedge RESET) begin
      if (RESET) begin
         r_state  <= ST_ADDR_H;
         r_addr_h <= 8'h00;
         r_addr   <= '0;
         r_op     <= 8'h00;
         r_cnt    <= 8'h00;
      end else begin
         r_state  <= w_state_nxt;
         r_addr_h <= w_addr_h_nxt;
         r_addr   <= w_addr_nxt;
         r_op     <= w_op_nxt;
         r_cnt    <= w_cnt_nxt;
      end
   end

   always_comb begin
      w_state_nxt  = r_state;
      w_addr_h_nxt = r_addr_h;
      w_addr_nxt   = r_addr;
      w_op_nxt     = r_op;
      w_cnt_nxt    = r_cnt;
      w_tx_data    = 8'h00;
      w_wr_en      = 1'b0;
      w_dv         = 1'b0;
      w_ck         = 1'b0;
      w_sp         = 1'b0;
      w_dbg        = 1'b0;
      w_done       = 1'b0;
      w_err_set    = 2'b00;
      w_err_clr    = 1'b0;
      if (w_byte_done) begin
         case (r_state)
            ST_ADDR_H: begin
               w_addr_h_nxt = w_rx_byte;
               w_state_nxt  = ST_ADDR_L;
            end
            ST_ADDR_L: begin
               w_addr_nxt  = ADDR_W'({r_addr_h, w_rx_byte});
               w_state_nxt = ST_OP;
            end
            ST_OP: begin
               w_op_nxt    = w_rx_byte;
               w_state_nxt = ST_DATA;
               if (w_rx_byte == OP_READ) begin
                  w_tx_data    = w_rd_byte;
                  w_err_set[0] = ~w_rd_ok;
               end
            end
            ST_DATA: begin
               w_state_nxt = ST_ADDR_H;
               w_done      = 1'b1;
               case (r_op)
                  OP_READ: ;
                  OP_WR, OP_WR_CLKDIV, OP_WR_SPIKE, OP_WR_DEBUG: begin
                     if (w_wr_ok) begin
                        w_wr_en = 1'b1;
                        w_dv    = 1'b1;
                        w_ck    = (r_op == OP_WR_CLKDIV) && (r_addr == c_clkdiv);
                        w_sp    = (r_op == OP_WR_SPIKE)  && (r_addr == c_spike_last);
                        w_dbg   = (r_op == OP_WR_DEBUG)  && (r_addr == c_debug);
                     end else begin
                        w_err_set[0] = 1'b1;
                     end
                  end
                  OP_BURST_WR, OP_BURST_RD: begin
                     if (w_rx_byte != 8'h00) begin
                        w_state_nxt = ST_BURST;
                        w_cnt_nxt   = w_rx_byte;
                        w_done      = 1'b0;
                        if (r_op == OP_BURST_RD) begin
                           w_tx_data    = w_rd_byte;
                           w_err_set[0] = ~w_rd_ok;
                        end
                     end
                  end
                  OP_CLR_ERR: w_err_clr = 1'b1;
                  default:    w_err_set[1] = 1'b1;
               endcase
            end
            ST_BURST: begin
               w_addr_nxt = r_addr + ADDR_W'(1);
               w_cnt_nxt  = r_cnt - 8'd1;
               if (r_op == OP_BURST_WR) begin
                  if (w_wr_ok) begin
                     w_wr_en = 1'b1;
                     w_dv    = 1'b1;
                  end else begin
                     w_err_set[0] = 1'b1;
                  end
               end else if (r_cnt != 8'd1) begin
                  w_tx_data    = w_rd_byte;
                  w_err_set[0] = ~w_rd_ok;
               end
               if (r_cnt == 8'd1) begin
                  w_state_nxt = ST_ADDR_H;
                  w_done      = 1'b1;
               end
            end
            default: w_state_nxt = ST_ADDR_H;
         endcase
      end
   end

   always_ff @(posedge SCLK or posedge RESET) begin
      if (RESET) begin
         for (int k = 0; k < MEM_BYTES; k++) r_mem[k] <= 8'h00;
         r_err  <= 2'b00;
         r_dv   <= 1'b0;
         r_ck   <= 1'b0;
         r_sp   <= 1'b0;
         r_dbg  <= 1'b0;
         r_done <= 1'b0;
      end else begin
         if (w_wr_en) r_mem[r_addr[IDX_W-1:0]] <= w_rx_byte;
         r_err  <= w_err_clr ? 2'b00 : (r_err | w_err_set);
         r_dv   <= w_dv;
         r_ck   <= w_ck;
         r_sp   <= w_sp;
         r_dbg  <= w_dbg;
         r_done <= w_done;
      end
   end

   generate
      for (genvar k = 0; k < MEM_BYTES; k++) begin : g_flat
         assign all_data_out[8*k +: 8] = r_mem[k];
      end
   endgenerate

   assign clk_div_ready_reg_out      = r_ck;
   assign input_spike_ready_reg_out  = r_sp;
   assign debug_config_ready_reg_out = r_dbg;
   assign data_valid_out             = r_dv;
   assign spi_instruction_done       = r_done;
   assign err_sticky                 = r_err;
endmodule
`default_nettype wire

// File: tb/tb_spi_param_interface.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_spi_param_interface
// Purpose  : Self-checking bench: instruction-level reference model of the
//            configuration memory, error flags, pulses and MISO read-back.
// Revision : 1.0 - initial release
// ============================================================================
module tb_spi_param_interface;
   localparam int MEM_BYTES   = 164;
   localparam int ADDR_W      = 16;
   localparam int SPIKE_BYTES = 3;
   localparam int CLKDIV_ADDR = 6;
   localparam int DEBUG_ADDR  = 163;

   logic                   SCLK = 1'b0;
   logic                   RESET;
   logic [MEM_BYTES*8-1:0] all_data_out;
   logic                   ck_rdy, sp_rdy, dbg_rdy, dv, done;
   logic [1:0]             err;

   spi_param_interface_if spi_bus ();

   spi_param_interface #(
      .MEM_BYTES(MEM_BYTES), .ADDR_W(ADDR_W), .SPIKE_BYTES(SPIKE_BYTES),
      .CLKDIV_ADDR(CLKDIV_ADDR), .DEBUG_ADDR(DEBUG_ADDR)
   ) dut (
      .SCLK                       (SCLK),
      .RESET                      (RESET),
      .spi                        (spi_bus),
      .all_data_out               (all_data_out),
      .clk_div_ready_reg_out      (ck_rdy),
      .input_spike_ready_reg_out  (sp_rdy),
      .debug_config_ready_reg_out (dbg_rdy),
      .data_valid_out             (dv),
      .spi_instruction_done       (done),
      .err_sticky                 (err)
   );

   always #5 SCLK = ~SCLK;

   int         n_vec = 0;
   int         n_bad = 0;
   logic [7:0] m_mem [MEM_BYTES];
   logic [1:0] m_err;
   logic [7:0] bq [$];

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [4:0] pulses();
      return {dv, ck_rdy, sp_rdy, dbg_rdy, done};
   endfunction

   function automatic logic [7:0] rd(input int a);
      return (a < MEM_BYTES) ? m_mem[a] : 8'h00;
   endfunction

   task automatic check_state();
      for (int k = 0; k < MEM_BYTES; k++)
         chk($sformatf("mem[%0d]", k), all_data_out[8*k +: 8], m_mem[k]);
      chk("err_sticky", err, m_err);
   endtask

   // Shifts one byte; optionally idles with SS high first. Ends on the
   // falling edge after the completing rising edge.
   task automatic send_byte(input logic [7:0] b, output logic [7:0] r);
      if ($urandom_range(0, 1) == 1) begin
         spi_bus.SS = 1'b1;
         repeat ($urandom_range(1, 2)) @(negedge SCLK);
      end
      for (int i = 7; i >= 0; i--) begin
         spi_bus.SS   = 1'b0;
         spi_bus.MOSI = b[i];
         r[i]         = spi_bus.MISO;
         @(posedge SCLK);
         @(negedge SCLK);
         if (i == 6) chk("pulse_clear", pulses(), 5'b0);
      end
   endtask

   task automatic xfer(input string tag, input logic [7:0] b,
                       input logic [7:0] exp_miso, input logic [4:0] exp_p);
      logic [7:0] r;
      send_byte(b, r);
      chk({tag, "_miso"}, r, exp_miso);
      chk({tag, "_pulses"}, pulses(), exp_p);
   endtask

   task automatic run_instr(input int addr, input logic [7:0] op, input logic [7:0] d);
      logic [4:0] p;
      logic [7:0] b, em;
      bit         wr, burst, ok;
      int         a;
      xfer("addr_h", addr[15:8], 8'h00, 5'b0);
      xfer("addr_l", addr[7:0],  8'h00, 5'b0);
      xfer("op",     op,         8'h00, 5'b0);
      ok    = addr < MEM_BYTES;
      wr    = op inside {8'h01, 8'h05, 8'h07, 8'h09};
      burst = (op == 8'h0B || op == 8'h0C) && d != 8'h00;
      em    = (op == 8'h00) ? rd(addr) : 8'h00;
      p     = 5'b0;
      p[0]  = !burst;
      if (op == 8'h00) begin
         if (!ok) m_err[0] = 1'b1;
      end else if (wr) begin
         if (ok) begin
            p[4] = 1'b1;
            p[3] = (op == 8'h05) && (addr == CLKDIV_ADDR);
            p[2] = (op == 8'h07) && (addr == SPIKE_BYTES - 1);
            p[1] = (op == 8'h09) && (addr == DEBUG_ADDR);
         end else begin
            m_err[0] = 1'b1;
         end
      end else if (op == 8'h0F) begin
         m_err = 2'b00;
      end else if (!(op inside {8'h0B, 8'h0C})) begin
         m_err[1] = 1'b1;
      end
      xfer("data", d, em, p);
      if (wr && ok) m_mem[addr] = d;
      a = addr;
      for (int j = 0; j < int'(d) && burst; j++) begin
         p    = 5'b0;
         p[0] = (j == int'(d) - 1);
         if (op == 8'h0B) begin
            b = (bq.size() > 0) ? bq.pop_front() : 8'($urandom);
            if (a < MEM_BYTES) begin
               p[4]     = 1'b1;
               m_mem[a] = b;
            end else begin
               m_err[0] = 1'b1;
            end
            xfer("burst_wr", b, 8'h00, p);
         end else begin
            em = rd(a);
            if (a >= MEM_BYTES) m_err[0] = 1'b1;
            xfer("burst_rd", 8'($urandom), em, p);
         end
         a = (a + 1) & 16'hFFFF;
      end
      check_state();
   endtask

   task automatic reset_model();
      for (int k = 0; k < MEM_BYTES; k++) m_mem[k] = 8'h00;
      m_err = 2'b00;
   endtask

   task automatic check_reset_outputs();
      chk("rst_pulses", pulses(), 5'b0);
      chk("rst_miso", spi_bus.MISO, 1'b0);
      check_state();
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [7:0] r;
      int         a;
      logic [7:0] op, d;
      reset_model();
      RESET        = 1'b1;
      spi_bus.SS   = 1'b1;
      spi_bus.MOSI = 1'b0;
      repeat (3) @(negedge SCLK);
      check_reset_outputs();
      RESET = 1'b0;
      @(negedge SCLK);

      // Directed scenarios
      run_instr(6, 8'h05, 8'hB6);
      run_instr(0, 8'h07, 8'hBA);
      run_instr(1, 8'h07, 8'hDC);
      run_instr(2, 8'h07, 8'hFE);
      chk("spike_word", all_data_out[23:0], 24'hFEDCBA);
      bq = '{8'h11, 8'h22, 8'h33, 8'h44};
      run_instr(7, 8'h0B, 8'h04);
      run_instr(7, 8'h0C, 8'h02);
      run_instr(16'h00A4, 8'h01, 8'h55);
      chk("err_oob", err, 2'b01);
      run_instr(3, 8'h3C, 8'h00);
      chk("err_both", err, 2'b11);
      run_instr(3, 8'h0F, 8'h00);
      chk("err_clear", err, 2'b00);
      run_instr(16'hFFFE, 8'h0B, 8'h04);
      run_instr(16'hFFFF, 8'h0C, 8'h03);
      run_instr(161, 8'h0B, 8'h05);
      run_instr(163, 8'h09, 8'h3D);
      run_instr(16'h1234, 8'h00, 8'h00);

      // Partial ADDR_L byte dropped by SS, then the full frame resumes
      xfer("addr_h", 8'h00, 8'h00, 5'b0);
      for (int i = 0; i < 4; i++) begin
         spi_bus.SS   = 1'b0;
         spi_bus.MOSI = 1'($urandom);
         @(posedge SCLK);
         @(negedge SCLK);
      end
      spi_bus.SS = 1'b1;
      @(negedge SCLK);
      xfer("addr_l", 8'h08, 8'h00, 5'b0);
      xfer("op", 8'h01, 8'h00, 5'b0);
      xfer("data", 8'h5A, 8'h00, 5'b10001);
      m_mem[8] = 8'h5A;
      check_state();

      // RESET mid-DATA with nonzero memory and error flags
      run_instr(3, 8'h77, 8'h00);
      xfer("addr_h", 8'h00, 8'h00, 5'b0);
      xfer("addr_l", 8'h09, 8'h00, 5'b0);
      xfer("op", 8'h01, 8'h00, 5'b0);
      for (int i = 0; i < 4; i++) begin
         spi_bus.SS   = 1'b0;
         spi_bus.MOSI = 1'b1;
         @(posedge SCLK);
         @(negedge SCLK);
      end
      #1 RESET = 1'b1;
      spi_bus.SS = 1'b1;
      #1;
      reset_model();
      check_reset_outputs();
      @(negedge SCLK);
      RESET = 1'b0;
      @(negedge SCLK);
      run_instr(6, 8'h05, 8'hB6);
      run_instr(0, 8'h00, 8'h00);

      // Randomised instruction stream
      for (int n = 0; n < 80; n++) begin
         case ($urandom_range(0, 5))
            0, 1, 2: a = $urandom_range(0, MEM_BYTES - 1);
            3: begin
               case ($urandom_range(0, 4))
                  0: a = 0;
                  1: a = 1;
                  2: a = SPIKE_BYTES - 1;
                  3: a = CLKDIV_ADDR;
                  default: a = DEBUG_ADDR;
               endcase
            end
            4: a = $urandom_range(MEM_BYTES, 16'hFFFF);
            default: a = ($urandom_range(0, 1) == 1) ? $urandom_range(16'hFFFC, 16'hFFFF)
                                                     : $urandom_range(MEM_BYTES - 4, MEM_BYTES - 1);
         endcase
         case ($urandom_range(0, 8))
            0: op = 8'h00;
            1: op = 8'h01;
            2: op = 8'h05;
            3: op = 8'h07;
            4: op = 8'h09;
            5: op = 8'h0B;
            6: op = 8'h0C;
            7: op = 8'h0F;
            default: begin
               op = 8'($urandom);
               if (op inside {8'h00, 8'h01, 8'h05, 8'h07, 8'h09, 8'h0B, 8'h0C, 8'h0F})
                  op = 8'h3C;
            end
         endcase
         d = (op == 8'h0B || op == 8'h0C) ? 8'($urandom_range(0, 5)) : 8'($urandom);
         run_instr(a, op, d);
      end

      spi_bus.SS = 1'b1;
      repeat (2) @(negedge SCLK);
      chk("idle_miso", spi_bus.MISO, 1'b0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule
`default_nettype wire

// File: doc/spi_param_interface.md
Name: spi_param_interface

Overview:
- Parametrised successor to the fixed 164-byte SPI configuration slave. Receives framed SPI byte transactions on SCLK and writes a parametrised configuration memory, exposed flat on all_data_out to the neuromorphic core.
- Adds read-back on MISO, burst write/read with address auto-increment, configurable special-register addresses, and sticky error reporting.

Parameters:
- MEM_BYTES, 164, number of configuration bytes (≥ SPIKE_BYTES+2).
- ADDR_W, 16, address width; transmitted as 2 bytes (MSB then LSB), upper bits zero-extended.
- SPIKE_BYTES, 3, input-spike bytes at addresses 0..SPIKE_BYTES-1.
- CLKDIV_ADDR, 6, clock-divider byte address.
- DEBUG_ADDR, 163, debug-config byte address (≤ MEM_BYTES-1).

Ports:
- SCLK  in  1  sole clock; all logic on rising edge.
- RESET  in  1  asynchronous, active-high; clears all state and memory.
- SS  in  1  active-low byte frame select.
- MOSI  in  1  serial data in, MSB first.
- MISO  out  1  serial data out, MSB first.
- all_data_out  out  MEM_BYTES*8  memory image; byte k at [8k+7:8k].
- clk_div_ready_reg_out  out  1  pulse: CLKDIV_ADDR written by op 0x05.
- input_spike_ready_reg_out  out  1  pulse: byte SPIKE_BYTES-1 written by op 0x07.
- debug_config_ready_reg_out  out  1  pulse: DEBUG_ADDR written by op 0x09.
- data_valid_out  out  1  pulse per committed memory byte write.
- spi_instruction_done  out  1  pulse at instruction end.
- err_sticky  out  2  [0] address out of range; [1] illegal opcode. Cleared only by RESET or op 0x0F.

Behaviour:
- Byte framing: bit counter advances on each rising SCLK with SS=0 and MOSI shifts in. The byte completes on the 8th such edge. SS=1 clears the bit counter, so a partial byte is discarded without advancing the FSM. SS may toggle between bytes.
- Frame FSM states: ADDR_H → ADDR_L → OP → DATA, then optionally BURST. Each transition occurs on byte completion. After an instruction completes, the FSM returns to ADDR_H.
- Opcodes:
  - 0x00: read; MISO shifts mem[addr] during DATA.
  - 0x01: plain write.
  - 0x05, 0x07, 0x09: write plus the corresponding ready pulse, only if the address matches the special address; otherwise plain write.
  - 0x0B: burst write; DATA byte is count N. Next N bytes (BURST) write addr, addr+1, and so on.
  - 0x0C: burst read; DATA byte = N. During the next N bytes, MISO shifts mem[addr+i]; MOSI is ignored.
  - 0x0F: clear err_sticky; DATA byte ignored.
  - Any other opcode: no write; the DATA byte is consumed; err_sticky[1] is set.
  - N=0 ends the instruction at DATA.
- Write commit: memory is updated on the edge completing the byte. data_valid_out and any ready pulse are high for exactly the following cycle.
- spi_instruction_done pulses in the cycle after the final byte: DATA, or the Nth BURST byte.
- MISO:
  - Read byte is loaded into the TX shifter on the edge completing the previous byte; bit 7 appears on MISO immediately.
  - MISO shifts left on each SS=0 rising edge.
  - MISO=0 when idle or not reading.
- Address range:
  - Address ≥ MEM_BYTES: writes dropped (no data_valid_out), reads return 0x00, err_sticky[0] set.
  - Burst address increments with ADDR_W wrap-around; out-of-range rules apply per byte.
- RESET asserted mid-frame: immediately zeroes memory, FSM (→ADDR_H), counters, pulses, MISO and err_sticky. The next frame starts fresh.
- Reset values: every output 0.

Decomposition:
- Package spi_if_pkg holds:
  - opcode localparams (OP_READ=0x00, OP_WR=0x01, OP_WR_CLKDIV=0x05, OP_WR_SPIKE=0x07, OP_WR_DEBUG=0x09, OP_BURST_WR=0x0B, OP_BURST_RD=0x0C, OP_CLR_ERR=0x0F);
  - FSM state encoding.
- Sub-module spi_byte_shifter: RX/TX 8-bit shift registers, bit counter, SS handling, byte_done strobe, parallel TX load.

Test Plan:
- Reset, then frame (00,06,05,B6) → mem[6]=B6; clk_div_ready_reg_out and data_valid_out high for 1 cycle; spi_instruction_done pulses once.
- op 0x07 to addresses 0,1,2 with BA,DC,FE → all_data_out[23:0]=FEDCBA; input_spike_ready_reg_out pulses only after address 2.
- Burst write (00,07,0B,04) then 11,22,33,44 → mem[7..10]=11,22,33,44; four data_valid_out pulses; one done pulse after last byte.
- Burst read (00,07,0C,02) → MISO bytes 11 then 22, MSB first.
- Write to 0x00A4 (MEM_BYTES=164) → no write, err_sticky=01. Opcode 0x3C → err_sticky=11. Op 0x0F → err_sticky=00.
- SS raised after 4 bits of ADDR_L, RESET asserted mid-DATA → partial byte discarded, FSM still at ADDR_L; after RESET, all outputs 0 and the next full frame writes correctly.
